// File: rtl/aes_wb_pkg.sv
// Shared definitions for both ends of the AES Wishbone link: FSM states,
// control-word constants, transfer counts and the control-word builder.
package aes_wb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_GAP,
        S_RD_GAP,
        S_RD_REQ,
        S_DONE
    } state_t;

    localparam logic [3:0]  CTRL_EN  = 4'hE;
    localparam logic [7:0]  CTRL_ENC = 8'hEC;
    localparam logic [7:0]  CTRL_DEC = 8'hDE;

    localparam int unsigned N_WR_WORDS = 9;
    localparam int unsigned N_RD_WORDS = 4;

    function automatic logic [31:0] ctrl_word(input logic text_first, input logic encrypt);
        return {3'b000, text_first, CTRL_EN, (encrypt ? CTRL_ENC : CTRL_DEC), 16'h0000};
    endfunction

endpackage

// File: rtl/aes_wb_word_mux.sv
// Selects write word[idx] of the 9-word sequence: two 128-bit blocks
// (order chosen by text_first), MSB word first, then the control word.
module aes_wb_word_mux
    import aes_wb_pkg::*;
(
    input  logic [127:0] key,
    input  logic [127:0] text,
    input  logic         text_first,
    input  logic         encrypt,
    input  logic [3:0]   idx,
    output logic [31:0]  word
);

    logic [127:0] blk;

    always_comb begin
        // words 0-3 come from the first block, 4-7 from the second
        blk  = (idx[2] ^ text_first) ? text : key;
        word = '0;
        if (idx[3]) begin
            word = ctrl_word(text_first, encrypt);
        end else begin
            unique case (idx[1:0])
                2'd0: word = blk[127:96];
                2'd1: word = blk[95:64];
                2'd2: word = blk[63:32];
                2'd3: word = blk[31:0];
                default: word = '0;
            endcase
        end
    end

endmodule

// File: rtl/aes_wb_initiator.sv
// Wishbone classic master feeding the AES slave: 9 writes, 4 reads, with idle gaps.
// Optional per-transfer abort is enabled by defining AES_WB_TIMEOUT_EN.
module aes_wb_initiator
    import aes_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic [127:0]  key_i,
    input  logic [127:0]  text_i,
    input  logic          encrypt_i,
    input  logic          text_first_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [127:0]  result_o,
    output logic          err_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    output logic [31:0]   wbm_adr_o,
    output logic [31:0]   wbm_dat_o,
    input  logic [31:0]   wbm_dat_i,
    input  logic          wbm_ack_i
);

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("aes_wb_initiator: GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state;
    logic [127:0]  key_q, text_q;
    logic          tf_q, enc_q;
    logic [3:0]    wcnt;
    logic [1:0]    rcnt;
    logic [31:0]   gcnt;
    logic          idle, in_req, timeout;
    logic [31:0]   next_word;

    assign idle   = (state == S_IDLE);
    assign in_req = (state == S_WR_REQ) || (state == S_RD_REQ);

    // In IDLE the first word is taken straight from the inputs being latched
    aes_wb_word_mux u_word_mux (
        .key        (idle ? key_i        : key_q),
        .text       (idle ? text_i       : text_q),
        .text_first (idle ? text_first_i : tf_q),
        .encrypt    (idle ? encrypt_i    : enc_q),
        .idx        (idle ? 4'd0         : wcnt),
        .word       (next_word)
    );

`ifdef AES_WB_TIMEOUT_EN
    logic [31:0] tcnt;

    assign timeout = in_req && !wbm_ack_i && (tcnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tcnt  <= '0;
            err_o <= 1'b0;
        end else begin
            tcnt <= (in_req && !wbm_ack_i && !timeout) ? tcnt + 32'd1 : '0;
            if (idle && start_i)
                err_o <= 1'b0;
            else if (timeout)
                err_o <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            key_q     <= '0;
            text_q    <= '0;
            tf_q      <= 1'b0;
            enc_q     <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            gcnt      <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            done_o <= 1'b0;
            // Any acked or aborted request drops the bus; cases below re-raise it
            if (in_req && (wbm_ack_i || timeout)) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= '0;
                wbm_adr_o <= '0;
                wbm_dat_o <= '0;
            end
            unique case (state)
                S_IDLE: if (start_i) begin
                    key_q     <= key_i;
                    text_q    <= text_i;
                    tf_q      <= text_first_i;
                    enc_q     <= encrypt_i;
                    wcnt      <= '0;
                    busy_o    <= 1'b1;
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= BASE_ADR;
                    wbm_dat_o <= next_word;
                    state     <= S_WR_REQ;
                end
                S_WR_REQ: if (wbm_ack_i) begin
                    gcnt <= '0;
                    if (wcnt == 4'(N_WR_WORDS - 1)) begin
                        rcnt  <= '0;
                        state <= S_RD_GAP;
                    end else begin
                        wcnt  <= wcnt + 4'd1;
                        state <= S_WR_GAP;
                    end
                end else if (timeout) begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                S_WR_GAP: if (gcnt == GAP_CYCLES - 1) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= BASE_ADR;
                    wbm_dat_o <= next_word;
                    state     <= S_WR_REQ;
                end else begin
                    gcnt <= gcnt + 32'd1;
                end
                S_RD_GAP: if (gcnt == GAP_CYCLES - 1) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_sel_o <= 4'hF;
                    wbm_adr_o <= BASE_ADR;
                    state     <= S_RD_REQ;
                end else begin
                    gcnt <= gcnt + 32'd1;
                end
                S_RD_REQ: if (wbm_ack_i) begin
                    gcnt <= '0;
                    unique case (rcnt)
                        2'd0: result_o[127:96] <= wbm_dat_i;
                        2'd1: result_o[95:64]  <= wbm_dat_i;
                        2'd2: result_o[63:32]  <= wbm_dat_i;
                        2'd3: result_o[31:0]   <= wbm_dat_i;
                        default: ;
                    endcase
                    if (rcnt == 2'(N_RD_WORDS - 1)) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        rcnt  <= rcnt + 2'd1;
                        state <= S_RD_GAP;
                    end
                end else if (timeout) begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
